// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Holds a shadow/active pair of packed BCD frames, commits only at frame
// boundaries, and drives one active-low anode per slot after a guard interval.
// All outputs are registered from the next-state values, so every output
// describes the same cycle as the internal slot/counter state.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic                          load,
  input  logic                          lz_en,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          pending,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  typedef enum logic {
    GUARD,
    ON
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx_next;
  logic [VAL_W-1:0] shadow, shadow_next;
  logic [VAL_W-1:0] active, active_next;
  logic             pending_next;
  logic             slot_end;
  logic             frame_end;
  logic             blank;
  logic [3:0]       bcd_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic             frame_done_next;

  // Slot sequencing: guard/on phases, in-slot counter, digit index with wrap.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = digit_idx;
    slot_end   = (cnt == CNT_W'(DIGIT_CYCLES - 1));
    frame_end  = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));
    case (state)
      GUARD:   if (cnt == CNT_W'(GUARD_CYCLES - 1)) state_next = ON;
      ON:      if (slot_end) state_next = GUARD;
      default: state_next = GUARD;
    endcase
    if (slot_end) begin
      cnt_next = '0;
      idx_next = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end
  end

  // Load/commit: a load on the frame-ending cycle goes straight to active.
  always_comb begin
    shadow_next  = shadow;
    active_next  = active;
    pending_next = pending;
    if (load) shadow_next = value_in;
    if (frame_end) begin
      pending_next = 1'b0;
      if (load)         active_next = value_in;
      else if (pending) active_next = shadow;
    end else if (load) begin
      pending_next = 1'b1;
    end
  end

  // Output decode for the upcoming cycle: nibble select, blanking, anode.
  always_comb begin
    bcd_next = '0;
    blank    = 1'b0;
    an_next  = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == IDX_W'(k)) begin
        bcd_next = active_next[4*k +: 4];
        blank    = lz_en && (k != 0) && ((active_next >> (4*k)) == '0);
      end
    end
    if (state_next == ON && !blank) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (idx_next == IDX_W'(k)) an_next[k] = 1'b0;
      end
    end
    frame_done_next = (cnt_next == CNT_W'(DIGIT_CYCLES - 1)) &&
                      (idx_next == IDX_W'(NUM_DIGITS - 1));
  end

  // State and registered outputs; reset aborts the scan with no commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GUARD;
      cnt        <= '0;
      digit_idx  <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      bcd_out    <= '0;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      digit_idx  <= idx_next;
      shadow     <= shadow_next;
      active     <= active_next;
      pending    <= pending_next;
      bcd_out    <= bcd_next;
      an         <= an_next;
      frame_done <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle
// guard). A frame-time model derives expected outputs from the cycle count
// since reset; directed scenarios are followed by randomized traffic.
module tb_sseg_scan_ctrl;

  localparam int N     = 4;
  localparam int DC    = 8;
  localparam int G     = 2;
  localparam int FRAME = N * DC;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        pending;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_t;
  logic [15:0] m_active, m_shadow;
  logic        m_pending;
  logic        m_lz;

  sseg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DIGIT_CYCLES(DC),
    .GUARD_CYCLES(G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .load      (load),
    .lz_en     (lz_en),
    .bcd_out   (bcd_out),
    .an        (an),
    .digit_idx (digit_idx),
    .pending   (pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
    end
  endtask

  // Expected outputs follow from position in the frame.
  task automatic check_all();
    int unsigned slot, pos;
    logic [3:0]  e_an;
    logic        blanked;
    slot    = (m_t / DC) % N;
    pos     = m_t % DC;
    blanked = m_lz && (slot != 0) && ((m_active >> (4*slot)) == 16'h0);
    e_an    = 4'hF;
    if (pos >= G && !blanked) e_an[slot] = 1'b0;
    chk("an",         {12'h0, an},          {12'h0, e_an});
    chk("bcd_out",    {12'h0, bcd_out},     (m_active >> (4*slot)) & 16'hF);
    chk("digit_idx",  {14'h0, digit_idx},   16'(slot));
    chk("pending",    {15'h0, pending},     {15'h0, m_pending});
    chk("frame_done", {15'h0, frame_done},  {15'h0, (m_t % FRAME) == FRAME-1});
  endtask

  // One clock: advance the model with the inputs of the ending cycle, then check.
  task automatic tick();
    logic fe;
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
    end else begin
      fe = ((m_t % FRAME) == FRAME-1);
      if (fe) begin
        if (load)           m_active = value_in;
        else if (m_pending) m_active = m_shadow;
        m_pending = 1'b0;
      end else if (load) begin
        m_pending = 1'b1;
      end
      if (load) m_shadow = value_in;
      m_t++;
    end
    m_lz = lz_en;
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the current cycle sits at a given frame offset.
  task automatic run_until(input int unsigned off);
    int i;
    for (i = 0; i < 2*FRAME; i++) begin
      if ((m_t % FRAME) == off) break;
      tick();
    end
    if ((m_t % FRAME) != off) begin
      checks++;
      failures++;
      $display("FAIL run_until offset=%0d observed=%0d", off, m_t % FRAME);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; value_in = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value_in = '0; lz_en = 1'b0;
    m_t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0; m_lz = 1'b0;

    // Reset and scan order
    ticks(3);
    rst = 1'b0;
    do_load(16'h1234);
    ticks(2*FRAME + 4);

    // Frame-atomic commit: loads in slots 2 and 3, last one wins
    run_until(2*DC + 3);
    do_load(16'h5678);
    run_until(3*DC + 1);
    do_load(16'h9999);
    ticks(2*FRAME);

    // Boundary bypass on the frame_done cycle
    run_until(FRAME - 1);
    do_load(16'hABCD);
    ticks(FRAME + 4);

    // Leading-zero blanking
    lz_en = 1'b1;
    do_load(16'h0050);
    ticks(2*FRAME);
    do_load(16'h0000);
    ticks(2*FRAME);
    lz_en = 1'b0;
    ticks(FRAME + 2);

    // Reset mid-operation with a pending load
    do_load(16'h4321);
    ticks(FRAME);
    run_until(DC + 1);
    do_load(16'h7777);
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(FRAME + 4);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      load = ($urandom_range(0, 11) == 0);
      value_in = ($urandom_range(0, 2) == 0) ? 16'($urandom) & 16'h00FF : 16'($urandom);
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      tick();
    end
    rst = 1'b0; load = 1'b0;
    ticks(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
